// File: rtl/demux1to2_32_buf.sv
// demux1to2_32_buf
//   Buffered 1-to-2 demultiplexer. Words arriving on a single valid/ready
//   input are steered by in_sel into one of two one-entry holding registers,
//   A (in_sel=0) or B (in_sel=1). Each register drives its own valid/ready
//   output, so a stalled consumer never blocks words bound for the other.
//
// Parameters
//   WIDTH  data width
//   CNT_W  width of the per-output delivery counters (wrap modulo 2^CNT_W)
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   flush                 synchronous clear of both holding registers
//   in_valid/in_ready     input handshake; in_sel picks the destination
//   in_sel, in_data       destination select and input word
//   a_valid/a_ready/a_data  output A handshake and held word
//   b_valid/b_ready/b_data  output B handshake and held word
//   a_count, b_count      words delivered on A / B
module demux1to2_32_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  logic a_room;
  logic b_room;
  logic load_a;
  logic load_b;
  logic drain_a;
  logic drain_b;

  // A register can take a word when empty or when its current word leaves
  // this same cycle; this keeps one word per cycle on a streaming output.
  assign a_room   = ~a_valid | a_ready;
  assign b_room   = ~b_valid | b_ready;
  assign in_ready = ~flush & (in_sel ? b_room : a_room);

  assign load_a  = in_valid & in_ready & ~in_sel & ~flush;
  assign load_b  = in_valid & in_ready &  in_sel & ~flush;
  assign drain_a = a_valid & a_ready;
  assign drain_b = b_valid & b_ready;

  // ---- holding register A ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_data  <= '0;
    end else begin
      // flush wins over everything; load wins over drain (replace in place)
      if (flush)
        a_valid <= 1'b0;
      else if (load_a)
        a_valid <= 1'b1;
      else if (drain_a)
        a_valid <= 1'b0;

      if (load_a)
        a_data <= in_data;
    end
  end

  // ---- holding register B ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid <= 1'b0;
      b_data  <= '0;
    end else begin
      if (flush)
        b_valid <= 1'b0;
      else if (load_b)
        b_valid <= 1'b1;
      else if (drain_b)
        b_valid <= 1'b0;

      if (load_b)
        b_data <= in_data;
    end
  end

  // ---- delivery counters ----
  // A drain handshake still completes during flush, so it is counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_count <= '0;
      b_count <= '0;
    end else begin
      if (drain_a)
        a_count <= a_count + 1'b1;
      if (drain_b)
        b_count <= b_count + 1'b1;
    end
  end

endmodule

// File: doc/demux1to2_32_buf.md
# demux1to2_32_buf

Buffered 1-to-2 demultiplexer: steers a 32-bit word stream arriving on one valid/ready input to one of two valid/ready outputs, selected per word by `in_sel`. It is the inverse of the datapath 2-to-1 select. It sits where a single producer, such as an ALU or memory result, feeds two consumers, such as the write-back path and a forwarding or debug sink. Each output has its own one-entry holding register, so a stalled consumer never blocks words bound for the other.

## Interface
Parameters:
- `WIDTH`, default 32: data width.
- `CNT_W`, default 16: width of per-output delivery counters.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear of both holding registers.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  input word accepted this cycle when `in_valid & in_ready`.
- `in_sel`  in  1  destination: 0 → A, 1 → B.
- `in_data`  in  WIDTH  input word.
- `a_valid`  out  1  A holding register full.
- `a_ready`  in  1  A consumer takes the word.
- `a_data`  out  WIDTH  A holding register contents.
- `b_valid`, `b_ready`, `b_data`: same as A, for output B.
- `a_count`  out  CNT_W  words delivered on A (`a_valid & a_ready`), wraps modulo 2^CNT_W.
- `b_count`  out  CNT_W  words delivered on B, same rule.

## Operation
- Each output X ∈ {A, B} has two states, EMPTY (`x_valid`=0) and FULL (`x_valid`=1).
  - EMPTY → FULL on load.
  - FULL → EMPTY on drain without load.
  - FULL → FULL on simultaneous drain and load, which replaces the data.
- Load to X: `in_valid & in_ready & (in_sel == X) & ~flush`.
- Drain of X: `x_valid & x_ready`.
- `in_ready = ~flush & (in_sel ? (~b_valid | b_ready) : (~a_valid | a_ready))`. This is a combinational function of `in_sel`, `flush`, the target state and the target ready. It is independent of `in_valid`.
- A word bound for A never waits on B, and vice versa.
- Back-to-back words to the same output achieve one word per cycle while that consumer holds ready high.
- `x_data` updates only on load. Its value while `x_valid`=0 is don't-care but holds its last value, and is 0 after reset.
- `x_valid`, `x_data` and `x_ready` are stable while FULL and not drained. `x_valid` never drops without a drain or flush.
- `flush`:
  - Clears `a_valid` and `b_valid` at the next edge.
  - Forces `in_ready`=0, so no input is accepted.
  - Counters still increment for a drain handshake in the flush cycle.
  - Data registers are not cleared.
- Counters increment by 1 per drain and wrap from 2^CNT_W−1 to 0. Both counters may increment in the same cycle.

## Timing
- Reset (async assert, any cycle): `a_valid`=`b_valid`=0, `a_data`=`b_data`=0, `a_count`=`b_count`=0. `in_ready` then follows its combinational rule (1 when `flush`=0).
- Reset deassert: first load possible at the first rising edge after deassert.
- Reset mid-transfer: a word held in a register is discarded, not delivered, and not counted.
- Latency: word accepted at edge N → `x_valid`=1 with that data after edge N, visible in cycle N+1.
- Simultaneous drain + load of the same X at edge N: the old word is delivered and counted, and the new word is held after N.
- Simultaneous load of A and drain of B, or the reverse: independent, both take effect.
- No combinational path from `in_data` to `x_data`. The output data is registered.

## Test plan
- Reset/idle: assert `rst` mid-cycle with `a_valid`=1 → `a_valid`, `b_valid`, `a_data`, `b_data`, `a_count` and `b_count` all 0 immediately; after release with `flush`=0, `in_ready`=1.
- Steering:
  - Send 0xDEADBEEF with sel=0, then 0x12345678 with sel=1, both consumers ready.
  - Required: A presents 0xDEADBEEF one cycle after acceptance and B presents 0x12345678 one cycle after its acceptance.
  - Required: `a_count`=1, `b_count`=1.
- Independence:
  - Hold `a_ready`=0 and load A with 0x1, then send 0x2, 0x3 with sel=1 and `b_ready`=1.
  - Required: `in_ready` is 1 for the B words, and B delivers 0x2 then 0x3 on consecutive cycles.
  - Required: `a_data` stays 0x1 and `a_valid` stays 1 throughout.
  - Required: the next sel=0 word sees `in_ready`=0 until `a_ready`=1.
- Full throughput: 8 consecutive words 0..7 to A with `a_ready`=1 → `in_ready` constantly 1, A delivers 0..7 on 8 consecutive cycles, `a_count`=8.
- Flush:
  - With A and B both FULL, assert `flush` for 1 cycle while `b_ready`=1 and `in_valid`=1.
  - Required: `in_ready`=0 during the flush cycle and the input word is not accepted.
  - Required: both `x_valid`=0 after the edge, `b_count` increments by 1 and `a_count` is unchanged.
- Counter wrap: with `CNT_W`=4, deliver 17 words on B → `b_count`=1; deliver 0 words on A → `a_count`=0.
